// File: rtl/logic16_pkg.sv
// Shared definitions for the logic16 arbiter: opcodes, FSM encoding and
// datapath width.
package logic16_pkg;

    localparam int DATA_W = 16;

    localparam logic [1:0] OP_NOT = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. Searches req starting at rr_ptr and
// wrapping modulo NUM_REQ; the pointer register is owned by the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_grant
);

    // One extra bit so rr_ptr + k never overflows before the wrap.
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] cand;

    // Walk the candidates in rotated order and keep the first valid one.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            cand = sum[ID_W-1:0];
            if (!any_grant && req[cand]) begin
                any_grant   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/logic16_arbiter.sv
// Round-robin front end for a shared combinational 16-bit logic unit.
// Optional build macro: LOGIC16_ARB_STATS_EN adds a saturating count of
// completed responses on ops_done; without it ops_done is constant zero.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Requesters hold valid and payload until they see ready; req_ready
// is one-hot or zero and only asserted in IDLE. rsp_valid, rsp_data and
// rsp_id stay stable from assertion until the cycle rsp_ready is seen.
module logic16_arbiter
    import logic16_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [2*NUM_REQ-1:0]      req_op,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    output logic [1:0]                lu_op,
    output logic [DATA_W-1:0]         lu_a,
    output logic [DATA_W-1:0]         lu_b,
    input  logic [DATA_W-1:0]         lu_out,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    output logic [15:0]               ops_done,
    output logic [1:0]                dbg_state
);

    state_t              state, state_nxt;
    logic [ID_W-1:0]     rr_ptr, ptr_nxt;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                any_grant;
    logic                accept;
    logic                rsp_hs;
    logic [1:0]          sel_op;
    logic [DATA_W-1:0]   sel_a, sel_b;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign dbg_state = state;
    assign rsp_hs    = (state == RESP) && rsp_ready;

    // Select the granted requester's payload.
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_op = req_op[2*i +: 2];
                sel_a  = req_a[DATA_W*i +: DATA_W];
                sel_b  = req_b[DATA_W*i +: DATA_W];
            end
        end
    end

    // Pointer moves to the slot just after the winner, wrapping at NUM_REQ-1.
    always_comb begin
        ptr_nxt = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);
    end

    // Next-state logic and the combinational accept strobe.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (any_grant) begin
                    req_ready = grant;
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, pointer, operand and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            lu_op     <= OP_NOT;
            lu_a      <= '0;
            lu_b      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lu_op  <= sel_op;
                lu_a   <= sel_a;
                lu_b   <= sel_b;
                rsp_id <= grant_idx;
                rr_ptr <= ptr_nxt;
            end
            if (state == EXEC) begin
                rsp_data  <= lu_out;
                rsp_valid <= 1'b1;
            end
            if (rsp_hs) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef LOGIC16_ARB_STATS_EN
    logic [15:0] ops_cnt;

    // Saturating count of response handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            ops_cnt <= '0;
        end else if (rsp_hs && (ops_cnt != 16'hFFFF)) begin
            ops_cnt <= ops_cnt + 16'd1;
        end
    end

    assign ops_done = ops_cnt;
`else
    assign ops_done = 16'h0000;
`endif

endmodule

// File: tb/tb_logic16_arbiter.sv
// Directed bench for logic16_arbiter with a behavioural model of the shared
// logic unit closing the lu_* loop.
module tb_logic16_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [2*N-1:0]  req_op;
    logic [16*N-1:0] req_a;
    logic [16*N-1:0] req_b;
    logic [1:0]      lu_op;
    logic [15:0]     lu_a, lu_b, lu_out;
    logic            rsp_valid, rsp_ready;
    logic [15:0]     rsp_data;
    logic [1:0]      rsp_id;
    logic [15:0]     ops_done;
    logic [1:0]      dbg_state;

    int errors = 0;
    int checks = 0;

    logic16_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .lu_op     (lu_op),
        .lu_a      (lu_a),
        .lu_b      (lu_b),
        .lu_out    (lu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .ops_done  (ops_done),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Shared logic unit
    always_comb begin
        case (lu_op)
            2'b00:   lu_out = ~lu_a;
            2'b01:   lu_out = lu_a & lu_b;
            2'b10:   lu_out = lu_a | lu_b;
            default: lu_out = lu_a ^ lu_b;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] op,
                           input logic [15:0] a, input logic [15:0] b);
        req_op[2*i +: 2]  = op;
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        req_op = '0; req_a = '0; req_b = '0;
        apply_reset();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_data !== 16'h0000 || rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp got data=%h id=%0d exp data=0000 id=0", rsp_data, rsp_id); end
        checks++; if (lu_op !== 2'b00 || lu_a !== 16'h0000 || lu_b !== 16'h0000) begin errors++; $display("FAIL reset_lu got op=%b a=%h b=%h exp 00/0000/0000", lu_op, lu_a, lu_b); end
        checks++; if (dbg_state !== 2'd0 || req_ready !== 4'b0000) begin errors++; $display("FAIL reset_idle got state=%0d ready=%b exp state=0 ready=0000", dbg_state, req_ready); end
        checks++; if (ops_done !== 16'h0000) begin errors++; $display("FAIL reset_ops_done got=%h exp=0000", ops_done); end
    endtask

    task automatic test_single_not();
        apply_reset();
        set_req(0, 2'b00, 16'h00FF, 16'h1234);
        req_valid = 4'b0001;
        settle();
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL not_ready got=%b exp=0001", req_ready); end
        step();
        req_valid = 4'b0000;
        checks++; if (lu_a !== 16'h00FF || lu_op !== 2'b00) begin errors++; $display("FAIL not_lu got a=%h op=%b exp a=00ff op=00", lu_a, lu_op); end
        checks++; if (dbg_state !== 2'd1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL not_exec got state=%0d rsp_valid=%b exp 1/0", dbg_state, rsp_valid); end
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'hFF00 || rsp_id !== 2'd0) begin errors++; $display("FAIL not_rsp got v=%b data=%h id=%0d exp v=1 data=ff00 id=0", rsp_valid, rsp_data, rsp_id); end
        step();
        checks++; if (rsp_valid !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL not_done got v=%b state=%0d exp v=0 state=0", rsp_valid, dbg_state); end
    endtask

    task automatic test_round_robin();
        logic [15:0] exp_d [4] = '{16'h1234, 16'h0F00, 16'hF0F0, 16'hFFFF};
        int g;
        apply_reset();
        set_req(0, 2'b10, 16'h1200, 16'h0034);
        set_req(1, 2'b01, 16'hFF00, 16'h0F0F);
        set_req(2, 2'b11, 16'hFFFF, 16'h0F0F);
        set_req(3, 2'b00, 16'h0000, 16'h5A5A);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        settle();
        for (int n = 0; n < 5; n++) begin
            g = n % 4;
            checks++; if (req_ready !== (4'b0001 << g)) begin errors++; $display("FAIL rr_grant[%0d] got=%b exp=%b", n, req_ready, 4'b0001 << g); end
            step();
            step();
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(g) || rsp_data !== exp_d[g]) begin errors++; $display("FAIL rr_rsp[%0d] got v=%b id=%0d data=%h exp v=1 id=%0d data=%h", n, rsp_valid, rsp_id, rsp_data, g, exp_d[g]); end
            step();
        end
    endtask

    task automatic test_backpressure();
        req_valid = 4'b0100;
        set_req(2, 2'b11, 16'hAAAA, 16'hFFFF);
        set_req(1, 2'b01, 16'h0F0F, 16'h00FF);
        rsp_ready = 1'b0;
        settle();
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant got=%b exp=0100", req_ready); end
        step();
        req_valid = 4'b0010;
        step();
        for (int c = 0; c < 5; c++) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h5555 || rsp_id !== 2'd2 || req_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall[%0d] got v=%b data=%h id=%0d ready=%b exp v=1 data=5555 id=2 ready=0000", c, rsp_valid, rsp_data, rsp_id, req_ready); end
            step();
        end
        rsp_ready = 1'b1;
        step();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin errors++; $display("FAIL bp_resume got v=%b ready=%b exp v=0 ready=0010", rsp_valid, req_ready); end
    endtask

    task automatic test_pointer_skip();
        logic [3:0]  vld [3] = '{4'b0010, 4'b0010, 4'b1010};
        logic [3:0]  gnt [3] = '{4'b0010, 4'b0010, 4'b1000};
        logic [1:0]  id  [3] = '{2'd1, 2'd1, 2'd3};
        logic [15:0] dat [3] = '{16'h0FF0, 16'h0FF0, 16'h0034};
        apply_reset();
        set_req(1, 2'b10, 16'h00F0, 16'h0F00);
        set_req(3, 2'b01, 16'h1234, 16'h00FF);
        rsp_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            req_valid = vld[n];
            settle();
            checks++; if (req_ready !== gnt[n]) begin errors++; $display("FAIL skip_grant[%0d] got=%b exp=%b", n, req_ready, gnt[n]); end
            step();
            step();
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== id[n] || rsp_data !== dat[n]) begin errors++; $display("FAIL skip_rsp[%0d] got v=%b id=%0d data=%h exp v=1 id=%0d data=%h", n, rsp_valid, rsp_id, rsp_data, id[n], dat[n]); end
            step();
        end
    endtask

    task automatic test_reset_mid_op();
        req_valid = 4'b0100;
        set_req(2, 2'b01, 16'hFFFF, 16'h1111);
        settle();
        step();
        checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL midrst_exec got state=%0d exp=1", dbg_state); end
        req_valid = 4'b0000;
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL midrst_clear got v=%b state=%0d exp v=0 state=0", rsp_valid, dbg_state); end
        step();
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_rsp got v=%b exp=0", rsp_valid); end
        set_req(0, 2'b00, 16'h00FF, 16'h0000);
        set_req(3, 2'b00, 16'h0000, 16'h0000);
        req_valid = 4'b1001;
        settle();
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_ptr got=%b exp=0001", req_ready); end
        step();
        req_valid = 4'b0000;
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'hFF00 || rsp_id !== 2'd0) begin errors++; $display("FAIL midrst_fresh got v=%b data=%h id=%0d exp v=1 data=ff00 id=0", rsp_valid, rsp_data, rsp_id); end
        step();
    endtask

    task automatic test_stats();
        logic [15:0] exp_ops;
`ifdef LOGIC16_ARB_STATS_EN
        exp_ops = 16'd3;
`else
        exp_ops = 16'd0;
`endif
        apply_reset();
        set_req(2, 2'b01, 16'hF0F0, 16'h0FF0);
        rsp_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            req_valid = 4'b0100;
            settle();
            step();
            req_valid = 4'b0000;
            step();
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h00F0) begin errors++; $display("FAIL stats_and[%0d] got v=%b data=%h exp v=1 data=00f0", n, rsp_valid, rsp_data); end
            step();
        end
        checks++; if (ops_done !== exp_ops) begin errors++; $display("FAIL stats_count got=%0d exp=%0d", ops_done, exp_ops); end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_single_not();
        test_round_robin();
        test_backpressure();
        test_pointer_skip();
        test_reset_mid_op();
        test_stats();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
